// File: rtl/bin32_to_bcd_conv.sv
// bin32_to_bcd_conv: sequential 32-bit binary to 8-digit packed BCD converter.
// Double dabble, one operand bit per clock; fixed 33-clock latency from the
// accepting edge to the done pulse. Result is held until the next DONE.
// Optional build macro: BCD_SATURATE_EN -- force bcd to 0x99999999 on overflow.
module bin32_to_bcd_conv (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] bin,
    output logic        busy,
    output logic        done,
    output logic [31:0] bcd,
    output logic        overflow
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state;
    logic [31:0] shreg;
    logic [39:0] scratch;
    logic [39:0] scratch_adj;
    logic [5:0]  bit_cnt;
    logic        ovf_next;
    logic [31:0] bcd_next;

    // Add 3 to every scratch digit that is 5 or more, all digits in parallel
    always_comb begin
        scratch_adj = scratch;
        for (int unsigned i = 0; i < 10; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    // Result presented in DONE: the upper two digits only feed the overflow flag
    always_comb begin
        ovf_next = (scratch[39:32] != '0);
`ifdef BCD_SATURATE_EN
        bcd_next = ovf_next ? 32'h9999_9999 : scratch[31:0];
`else
        bcd_next = scratch[31:0];
`endif
    end

    // Conversion FSM: capture, 32 adjust-then-shift steps, publish result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            scratch  <= '0;
            bit_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shreg   <= bin;
                        scratch <= '0;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    scratch <= {scratch_adj[38:0], shreg[31]};
                    shreg   <= {shreg[30:0], 1'b0};
                    bit_cnt <= bit_cnt + 6'd1;
                    if (bit_cnt == 6'd31) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    bcd      <= bcd_next;
                    overflow <= ovf_next;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin32_to_bcd_conv.sv
// Testbench for bin32_to_bcd_conv: scoreboard of expected results pushed at
// each accepted start and popped on every done pulse.
module tb_bin32_to_bcd_conv;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] bin;
    logic        busy;
    logic        done;
    logic [31:0] bcd;
    logic        overflow;

    bin32_to_bcd_conv dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .overflow (overflow)
    );

    typedef struct {
        logic [31:0] bcd;
        logic        ovf;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   errors  = 0;
    int   checks  = 0;
    int   cyc     = 0;
    int   done_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [31:0] v, input int due);
        exp_t e;
        int unsigned r;
        r = v % 32'd100000000;
        e.ovf = (v >= 32'd100000000);
        for (int d = 0; d < 8; d++) begin
            e.bcd[4*d +: 4] = 4'(r % 10);
            r = r / 10;
        end
`ifdef BCD_SATURATE_EN
        if (e.ovf) e.bcd = 32'h9999_9999;
`endif
        e.due = due;
        return e;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest pending result
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt = done_cnt + 1;
            if (exp_q.size() == 0) begin
                check("unexpected_done", {63'd0, done}, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("bcd", {32'd0, bcd}, {32'd0, e.bcd});
                check("overflow", {63'd0, overflow}, {63'd0, e.ovf});
                check("latency", 64'(cyc), 64'(e.due));
            end
        end
    end

    task automatic wait_idle();
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            #1;
            if (!busy) break;
        end
    endtask

    task automatic wait_done(input int prev);
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            #1;
            if (done_cnt != prev) break;
        end
        check("done_seen", 64'(done_cnt - prev), 64'd1);
    endtask

    // Drive one accepted start; caller is at a negedge with the DUT idle
    task automatic issue(input logic [31:0] v);
        start = 1'b1;
        bin   = v;
        exp_q.push_back(model(v, cyc + 1 + 33));
    endtask

    task automatic convert(input logic [31:0] v);
        int prev;
        wait_idle();
        prev = done_cnt;
        issue(v);
        @(negedge clk);
        start = 1'b0;
        wait_done(prev);
    endtask

    initial begin
        int prev;
        rst_n = 1'b0;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_bcd", {32'd0, bcd}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_ovf", {63'd0, overflow}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed operands, including the overflow boundary
        convert(32'd0);
        convert(32'd12345678);
        convert(32'd99999999);
        convert(32'd9);
        convert(32'd100000000);
        convert(32'hFFFF_FFFF);

        // start while busy is ignored; bin changes after capture have no effect
        wait_idle();
        prev = done_cnt;
        issue(32'd42);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        start = 1'b1;
        bin   = 32'd7;
        @(negedge clk);
        start = 1'b0;
        bin   = 32'h1234_5678;
        wait_done(prev);
        repeat (6) @(negedge clk);
        #1;
        check("single_done", 64'(done_cnt - prev), 64'd1);
        convert(32'd7);

        // Asynchronous reset mid-conversion aborts without a done pulse
        wait_idle();
        prev  = done_cnt;
        start = 1'b1;
        bin   = 32'd555;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_bcd", {32'd0, bcd}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_ovf", {63'd0, overflow}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        check("abort_no_done", 64'(done_cnt - prev), 64'd0);
        convert(32'd555);

        // Random sweep below 10^8
        for (int n = 0; n < 1000; n++) begin
            convert($urandom_range(99999999, 0));
        end

        // start held high: back-to-back conversions every 34 clocks
        wait_idle();
        prev  = done_cnt;
        start = 1'b1;
        bin   = 32'd31415926;
        for (int j = 0; j < 4; j++) begin
            exp_q.push_back(model(32'd31415926, cyc + 1 + 33 + 34 * j));
        end
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            #1;
            if (done_cnt - prev == 4) break;
        end
        start = 1'b0;
        check("b2b_dones", 64'(done_cnt - prev), 64'd4);
        repeat (40) @(negedge clk);
        #1;
        check("b2b_no_extra", 64'(done_cnt - prev), 64'd4);

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        check("global_timeout", 64'd1, 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "FAIL global_timeout: simulation did not complete");
    end

endmodule
